// File: rtl/multiport_freelist_if.sv
// Rename/commit handshake bundle for the physical-register free list.
// The master side is the rename/commit logic; the slave side is the free list.
interface multiport_freelist_if #(
    parameter int DEQ_PORTS = 2,
    parameter int ENQ_PORTS = 2,
    parameter int PW        = 6,
    parameter int CW        = 6
);
    logic [DEQ_PORTS-1:0]         deq_req;
    logic                         deq_grant;
    logic [DEQ_PORTS-1:0][PW-1:0] deq_preg;
    logic [ENQ_PORTS-1:0]         enq_valid;
    logic [ENQ_PORTS-1:0][PW-1:0] enq_preg;
    logic                         flush;
    logic [CW-1:0]                free_count;
    logic                         empty;
    logic                         full;
    logic                         err_overflow;
    logic                         err_underflow;

    modport master (
        output deq_req, enq_valid, enq_preg, flush,
        input  deq_grant, deq_preg, free_count, empty, full, err_overflow, err_underflow
    );

    modport slave (
        input  deq_req, enq_valid, enq_preg, flush,
        output deq_grant, deq_preg, free_count, empty, full, err_overflow, err_underflow
    );
endinterface

// File: rtl/multiport_freelist.sv
// Multi-port circular free list of physical registers. Allocation is all-or-nothing
// per cycle; frees are compacted at the tail; flush restores a full list behind the tail.
module multiport_freelist #(
    parameter int PHYS_REGS = 64,
    parameter int ARCH_REGS = 32,
    parameter int DEQ_PORTS = 2,
    parameter int ENQ_PORTS = 2,
    localparam int DEPTH    = PHYS_REGS - ARCH_REGS,
    localparam int PW       = $clog2(PHYS_REGS),
    localparam int CW       = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    multiport_freelist_if.slave    bus
);
    // Extra headroom so free_count + m never wraps before the overflow test.
    localparam int XW = CW + 2;

    logic [PW-1:0]                entry [DEPTH];
    logic [CW-1:0]                head, tail, free_count;
    logic                         err_ovf, err_unf;

    logic [XW-1:0]                k, m, kg, sum, fc_next;
    logic [DEQ_PORTS-1:0][CW-2:0] deq_off, rd_idx;
    logic [ENQ_PORTS-1:0][CW-2:0] enq_off, wr_idx;
    logic                         grant, enq_acc, enq_drop;
    logic [CW-1:0]                tail_next, head_next;

    // Per-port offset is the number of asserted ports below it.
    always_comb begin
        k = '0;
        for (int i = 0; i < DEQ_PORTS; i++) begin
            deq_off[i] = k[CW-2:0];
            k          = k + XW'(bus.deq_req[i]);
        end
        m = '0;
        for (int j = 0; j < ENQ_PORTS; j++) begin
            enq_off[j] = m[CW-2:0];
            m          = m + XW'(bus.enq_valid[j]);
        end
    end

    generate
        for (genvar i = 0; i < DEQ_PORTS; i++) begin : g_rd
            assign rd_idx[i]       = head[CW-2:0] + deq_off[i];
            assign bus.deq_preg[i] = entry[rd_idx[i]];
        end
        for (genvar j = 0; j < ENQ_PORTS; j++) begin : g_wr
            assign wr_idx[j] = tail[CW-2:0] + enq_off[j];
        end
    endgenerate

    // Grant sees only the registered count: same-cycle frees are not bypassed.
    assign grant     = (k <= XW'(free_count)) && !bus.flush && !rst;
    assign kg        = grant ? k : '0;
    assign sum       = XW'(free_count) - kg + m;
    assign enq_acc   = (sum <= XW'(DEPTH));
    assign enq_drop  = (m != '0) && !enq_acc;
    assign tail_next = tail + (enq_acc ? m[CW-1:0] : '0);
    assign head_next = bus.flush ? (tail_next - CW'(DEPTH)) : (head + kg[CW-1:0]);
    assign fc_next   = bus.flush ? XW'(DEPTH) : (enq_acc ? sum : (XW'(free_count) - kg));

    always_ff @(posedge clk) begin
        if (rst) begin
            head       <= '0;
            tail       <= CW'(DEPTH);
            free_count <= CW'(DEPTH);
            err_ovf    <= 1'b0;
            err_unf    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) entry[i] <= PW'(ARCH_REGS + i);
        end else begin
            head       <= head_next;
            tail       <= tail_next;
            free_count <= fc_next[CW-1:0];
            err_ovf    <= err_ovf | enq_drop;
            err_unf    <= err_unf | (free_count > CW'(DEPTH));
            if (enq_acc) begin
                for (int j = 0; j < ENQ_PORTS; j++)
                    if (bus.enq_valid[j]) entry[wr_idx[j]] <= bus.enq_preg[j];
            end
        end
    end

    assign bus.deq_grant     = grant;
    assign bus.free_count    = free_count;
    assign bus.empty         = (free_count == '0);
    assign bus.full          = (free_count == CW'(DEPTH));
    assign bus.err_overflow  = err_ovf;
    assign bus.err_underflow = err_unf;
endmodule

// File: tb/tb_multiport_freelist.sv
// Directed and scoreboarded checks of the multi-port free list (64 phys / 32 arch, 2x2 ports).
module tb_multiport_freelist;
    localparam int PW = 6;
    localparam int CW = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multiport_freelist_if #(.DEQ_PORTS(2), .ENQ_PORTS(2), .PW(PW), .CW(CW)) bus ();

    multiport_freelist #(
        .PHYS_REGS(64), .ARCH_REGS(32), .DEQ_PORTS(2), .ENQ_PORTS(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.deq_req   = '0;
        bus.enq_valid = '0;
        bus.enq_preg  = '0;
        bus.flush     = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Scoreboard state for the random phase
    int q[$];
    int inuse[$];
    bit busy [64];

    initial begin
        idle();
        do_reset();

        // Reset state, and grant held low while rst is high
        check("rst_fc", bus.free_count, 32);
        check("rst_full", bus.full, 1);
        check("rst_empty", bus.empty, 0);
        check("rst_ovf", bus.err_overflow, 0);
        check("rst_unf", bus.err_underflow, 0);
        rst = 1'b1; bus.deq_req = 2'b11; #1;
        check("rst_grant", bus.deq_grant, 0);
        tick(); rst = 1'b0; idle(); #1;
        check("rst_dom_fc", bus.free_count, 32);

        // Two-port allocation right after reset
        bus.deq_req = 2'b11; #1;
        check("d11_grant", bus.deq_grant, 1);
        check("d11_p0", bus.deq_preg[0], 32);
        check("d11_p1", bus.deq_preg[1], 33);
        tick(); idle(); #1;
        check("d11_fc", bus.free_count, 30);
        check("d11_full", bus.full, 0);

        // Single upper port gets the head entry; head advances by one
        do_reset();
        bus.deq_req = 2'b10; #1;
        check("d10_grant", bus.deq_grant, 1);
        check("d10_p1", bus.deq_preg[1], 32);
        tick();
        bus.deq_req = 2'b01; #1;
        check("d01_p0", bus.deq_preg[0], 33);
        tick(); idle(); #1;
        check("d01_fc", bus.free_count, 30);

        // Overflowing enqueue group is dropped and the flag sticks
        do_reset();
        bus.deq_req = 2'b01; tick(); idle(); #1;
        check("ovf_pre_fc", bus.free_count, 31);
        bus.enq_valid = 2'b11; bus.enq_preg[0] = 6'd1; bus.enq_preg[1] = 6'd2;
        tick(); idle(); #1;
        check("ovf_fc", bus.free_count, 31);
        check("ovf_flag", bus.err_overflow, 1);
        tick(); #1;
        check("ovf_sticky", bus.err_overflow, 1);
        bus.deq_req = 2'b01; #1;
        check("ovf_next_p0", bus.deq_preg[0], 33);
        tick(); idle();

        // Drain to one, denied pair, last entry, then refill across the wrap
        do_reset();
        for (int i = 0; i < 15; i++) begin bus.deq_req = 2'b11; tick(); end
        bus.deq_req = 2'b01; tick(); idle(); #1;
        check("drain_fc", bus.free_count, 1);
        bus.deq_req = 2'b11; #1;
        check("deny_grant", bus.deq_grant, 0);
        tick(); idle(); #1;
        check("deny_fc", bus.free_count, 1);
        check("deny_unf", bus.err_underflow, 0);
        bus.deq_req = 2'b01; #1;
        check("last_p0", bus.deq_preg[0], 63);
        tick(); idle(); #1;
        check("empty_fc", bus.free_count, 0);
        check("empty_flag", bus.empty, 1);
        bus.deq_req = 2'b01; bus.enq_valid = 2'b11;
        bus.enq_preg[0] = 6'd10; bus.enq_preg[1] = 6'd11; #1;
        check("nobypass_grant", bus.deq_grant, 0);
        tick(); idle(); #1;
        check("refill_fc", bus.free_count, 2);
        bus.deq_req = 2'b11; #1;
        check("wrap_p0", bus.deq_preg[0], 10);
        check("wrap_p1", bus.deq_preg[1], 11);
        tick(); idle(); #1;
        check("wrap_fc", bus.free_count, 0);

        // Flush recovery with a same-cycle free
        do_reset();
        bus.deq_req = 2'b11; tick(); tick();
        bus.deq_req = 2'b01; tick(); idle(); #1;
        check("fl_alloc_fc", bus.free_count, 27);
        bus.enq_valid = 2'b11; bus.enq_preg[0] = 6'd40; bus.enq_preg[1] = 6'd41;
        tick(); idle(); #1;
        check("fl_free_fc", bus.free_count, 29);
        bus.flush = 1'b1; bus.deq_req = 2'b11;
        bus.enq_valid = 2'b01; bus.enq_preg[0] = 6'd50; #1;
        check("fl_grant", bus.deq_grant, 0);
        tick(); idle(); #1;
        check("fl_fc", bus.free_count, 32);
        check("fl_full", bus.full, 1);
        bus.deq_req = 2'b11; #1;
        check("fl_p0", bus.deq_preg[0], 35);
        check("fl_p1", bus.deq_preg[1], 36);
        tick(); idle(); #1;
        check("fl_after_fc", bus.free_count, 30);

        // Random traffic against a queue scoreboard
        do_reset();
        q.delete(); inuse.delete();
        for (int r = 0; r < 64; r++) busy[r] = 1'b0;
        for (int r = 32; r < 64; r++) q.push_back(r);
        for (int cyc = 0; cyc < 200; cyc++) begin
            logic [1:0] dq, en;
            int freed[$];
            int kk, ix;
            dq = 2'($urandom_range(0, 3));
            en = 2'b00;
            freed.delete();
            for (int j = 0; j < 2; j++) begin
                if (inuse.size() > 0 && $urandom_range(0, 1) == 1) begin
                    ix = $urandom_range(0, inuse.size() - 1);
                    en[j] = 1'b1;
                    bus.enq_preg[j] = 6'(inuse[ix]);
                    freed.push_back(inuse[ix]);
                    inuse.delete(ix);
                end else begin
                    bus.enq_preg[j] = '0;
                end
            end
            bus.deq_req = dq; bus.enq_valid = en; #1;
            kk = int'(dq[0]) + int'(dq[1]);
            check("rnd_grant", bus.deq_grant, (kk <= q.size()) ? 1 : 0);
            if (kk <= q.size()) begin
                for (int i = 0; i < 2; i++) begin
                    if (dq[i]) begin
                        int rg;
                        rg = q.pop_front();
                        check("rnd_preg", bus.deq_preg[i], rg);
                        check("rnd_dup", busy[rg], 0);
                        busy[rg] = 1'b1;
                        inuse.push_back(rg);
                    end
                end
            end
            foreach (freed[f]) begin
                busy[freed[f]] = 1'b0;
                q.push_back(freed[f]);
            end
            tick();
            check("rnd_fc", bus.free_count, q.size());
        end
        idle();
        check("rnd_ovf", bus.err_overflow, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
